// File: rtl/tx_readout_control_pkg.sv
// Shared sizing constants and FSM state encoding for the TX buffer readout controller.
package tx_readout_control_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5
  } state_t;

endpackage

// File: rtl/tx_readout_control_edge_detect.sv
// Synchronous rising-edge detector; the sample resets to 1 so a level held
// high through reset is not seen as an edge.
module edge_detect (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_d;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_d <= 1'b1;
    end else begin
      r_d <= i_d;
    end
  end

  assign o_rise = i_d & ~r_d;

endmodule

// File: rtl/tx_readout_control.sv
// Reads word_count buffer entries back one at a time and hands each to a UART
// transmitter, waiting for tx_done between bytes.
module tx_readout_control #(
  parameter int DEPTH  = tx_readout_control_pkg::DEPTH,
  parameter int ADDR_W = tx_readout_control_pkg::ADDR_W,
  parameter int DATA_W = tx_readout_control_pkg::DATA_W
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tx_dv,
  output logic [DATA_W-1:0] tx_byte,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count_tx
);

  import tx_readout_control_pkg::*;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_start_rise;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_tx_byte;
  logic [ADDR_W:0]   r_count_tx;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_last;

  edge_detect u_start_edge (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .i_d      (start),
    .o_rise   (w_start_rise)
  );

  assign w_count_inc = r_count_tx + 1'b1;
  assign w_last      = (w_count_inc == r_len);

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Start edges are only looked at in IDLE, so edges while busy are dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = (word_count == '0) ? FINISH : FETCH;
        end
      end
      FETCH:     w_state_nxt = LOAD;
      LOAD:      w_state_nxt = SEND;
      SEND:      w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          w_state_nxt = w_last ? FINISH : FETCH;
        end
      end
      FINISH:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_dv = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (r_state)
      IDLE:    busy  = 1'b0;
      SEND:    tx_dv = 1'b1;
      FINISH:  done  = 1'b1;
      default: ;
    endcase
  end

  // Length is clamped at latch time, which also bounds rd_addr to DEPTH-1.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_len      <= '0;
      r_rd_addr  <= '0;
      r_tx_byte  <= '0;
      r_count_tx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_rise) begin
            r_len      <= (word_count > LEN_MAX) ? LEN_MAX : word_count;
            r_rd_addr  <= '0;
            r_count_tx <= '0;
          end
        end
        LOAD: r_tx_byte <= rd_data;
        WAIT_DONE: begin
          if (tx_done) begin
            r_count_tx <= w_count_inc;
            if (!w_last) begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr  = r_rd_addr;
  assign tx_byte  = r_tx_byte;
  assign count_tx = r_count_tx;

endmodule

// File: tb/tb_tx_readout_control.sv
// Bench for tx_readout_control: buffer and UART models plus a per-transfer
// reference derived from word_count, the memory contents and the tx_done delay.
module tb_tx_readout_control;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              CLOCK_50 = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] rd_data;
  logic              tx_done;
  logic [ADDR_W-1:0] rd_addr;
  logic              tx_dv;
  logic [DATA_W-1:0] tx_byte;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count_tx;

  logic r_resp  = 1'b0;
  logic r_stray = 1'b0;
  assign tx_done = r_resp | r_stray;

  always #10 CLOCK_50 = ~CLOCK_50;

  tx_readout_control #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .rd_data    (rd_data),
    .tx_done    (tx_done),
    .rd_addr    (rd_addr),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .done       (done),
    .count_tx   (count_tx)
  );

  // Buffer with one cycle of read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge CLOCK_50) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Monitor: logs every tx_dv/done and checks tx_byte stays put until tx_done.
  int               dv_cyc[$];
  int               dv_addr[$];
  logic [DATA_W-1:0] dv_byte[$];
  int               done_cyc[$];
  int               n_busy = 0;
  int               stable_err = 0;
  logic [DATA_W-1:0] cur_byte;
  bit               inflight = 1'b0;

  always @(negedge CLOCK_50) begin
    if (busy === 1'b1) n_busy++;
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (tx_dv === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_addr.push_back(int'(rd_addr));
      dv_byte.push_back(tx_byte);
      cur_byte = tx_byte;
      inflight = 1'b1;
    end else if (inflight) begin
      if (tx_byte !== cur_byte) stable_err++;
      if (tx_done === 1'b1) inflight = 1'b0;
    end
    if (rst === 1'b1) inflight = 1'b0;
  end

  // UART model: answers each tx_dv with a tx_done resp_delay cycles later,
  // unless a reset (gen bump) intervened.
  int resp_delay = 4;
  int gen = 0;
  initial begin : responder
    int g;
    forever begin
      @(negedge CLOCK_50);
      if (tx_dv === 1'b1) begin
        g = gen;
        repeat (resp_delay) @(posedge CLOCK_50);
        #5;
        if (g == gen) begin
          r_resp = 1'b1;
          @(posedge CLOCK_50);
          #5;
          r_resp = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  int last_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  // One transfer, checked against: bytes mem[0..len-1] at addresses 0..len-1,
  // first tx_dv 3 edges after the start edge, dly+3 cycles between bytes,
  // a single done at t0 + len*(dly+3) + 1 and busy for exactly that span.
  task automatic xfer(input int wc, input int dly, input bit disturb, input bit hold,
                      input bit rnd_mem, input string tag);
    int len, t0, w, b_dv, b_done, b_busy, b_se, n_dv, exp_cyc;
    len = (wc > DEPTH) ? DEPTH : wc;
    if (rnd_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
    end
    resp_delay = dly;
    word_count = (ADDR_W+1)'(wc);
    b_dv   = dv_cyc.size();
    b_done = done_cyc.size();
    b_busy = n_busy;
    b_se   = stable_err;
    start  = 1'b1;
    t0     = cyc;
    w      = 0;
    while (done_cyc.size() == b_done && w < 3000) begin
      tick();
      w++;
      if (disturb && w == 6) start = 1'b0;
      if (disturb && w == 8) begin
        start      = 1'b1;
        word_count = word_count + 5'd5;
      end
    end
    check({tag, " done_seen"}, 32'(w < 3000), 32'd1);
    repeat (3) tick();
    n_dv = dv_cyc.size() - b_dv;
    check({tag, " n_tx_dv"}, 32'(n_dv), 32'(len));
    check({tag, " n_done"}, 32'(done_cyc.size() - b_done), 32'd1);
    exp_cyc = t0 + 3;
    for (int i = 0; i < len && i < n_dv; i++) begin
      check({tag, " byte"}, 32'(dv_byte[b_dv+i]), 32'(mem[i]));
      check({tag, " addr"}, 32'(dv_addr[b_dv+i]), 32'(i));
      check({tag, " dv_cycle"}, 32'(dv_cyc[b_dv+i]), 32'(exp_cyc));
      exp_cyc += dly + 3;
    end
    if (done_cyc.size() > b_done)
      check({tag, " done_cycle"}, 32'(done_cyc[b_done]), 32'(t0 + len*(dly+3) + 1));
    check({tag, " busy_cycles"}, 32'(n_busy - b_busy), 32'(len*(dly+3) + 1));
    check({tag, " count_tx"}, 32'(count_tx), 32'(len));
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " tx_byte_stable"}, 32'(stable_err - b_se), 32'd0);
    last_len = len;
    if (!hold) begin
      start = 1'b0;
      tick();
    end
  endtask

  initial begin : main
    int b_dv, b_busy, w;
    rst        = 1'b1;
    start      = 1'b1;
    word_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) tick();
    check("rst rd_addr",  32'(rd_addr),  32'd0);
    check("rst tx_dv",    32'(tx_dv),    32'd0);
    check("rst tx_byte",  32'(tx_byte),  32'd0);
    check("rst busy",     32'(busy),     32'd0);
    check("rst done",     32'(done),     32'd0);
    check("rst count_tx", 32'(count_tx), 32'd0);

    // start held high through reset must not launch
    rst    = 1'b0;
    b_dv   = dv_cyc.size();
    b_busy = n_busy;
    repeat (20) tick();
    check("held_through_rst dv",   32'(dv_cyc.size() - b_dv), 32'd0);
    check("held_through_rst busy", 32'(n_busy - b_busy),      32'd0);
    start = 1'b0;
    tick();

    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    xfer(3, 10, 1'b0, 1'b0, 1'b0, "basic3");
    xfer(0, 4, 1'b0, 1'b0, 1'b1, "zero");
    xfer(16, 2, 1'b0, 1'b0, 1'b1, "full16");
    for (int k = 0; k < 5; k++) begin
      xfer(int'($urandom_range(1, 31)), int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b1, "rand");
    end

    // stray tx_done in IDLE
    b_dv    = dv_cyc.size();
    b_busy  = n_busy;
    r_stray = 1'b1;
    tick();
    r_stray = 1'b0;
    repeat (4) tick();
    check("stray count_tx", 32'(count_tx), 32'(last_len));
    check("stray busy",     32'(n_busy - b_busy), 32'd0);
    check("stray dv",       32'(dv_cyc.size() - b_dv), 32'd0);

    xfer(4, 4, 1'b1, 1'b0, 1'b1, "disturb");

    // reset while waiting for tx_done of the second byte
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
    resp_delay = 10;
    word_count = 5'd5;
    b_dv  = dv_cyc.size();
    start = 1'b1;
    w     = 0;
    while (dv_cyc.size() - b_dv < 2 && w < 500) begin
      tick();
      w++;
    end
    check("abort second_dv_seen", 32'(w < 500), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    gen++;
    tick();
    check("abort rd_addr",  32'(rd_addr),  32'd0);
    check("abort tx_dv",    32'(tx_dv),    32'd0);
    check("abort tx_byte",  32'(tx_byte),  32'd0);
    check("abort busy",     32'(busy),     32'd0);
    check("abort done",     32'(done),     32'd0);
    check("abort count_tx", 32'(count_tx), 32'd0);
    rst    = 1'b0;
    b_dv   = dv_cyc.size();
    b_busy = n_busy;
    repeat (25) tick();
    check("abort no_relaunch dv",   32'(dv_cyc.size() - b_dv), 32'd0);
    check("abort no_relaunch busy", 32'(n_busy - b_busy),      32'd0);
    start = 1'b0;
    tick();
    xfer(5, 3, 1'b0, 1'b0, 1'b1, "restart");

    // start left high after done must not retrigger
    xfer(2, 2, 1'b0, 1'b1, 1'b1, "hold");
    b_dv   = dv_cyc.size();
    b_busy = n_busy;
    repeat (30) tick();
    check("hold no_second dv",   32'(dv_cyc.size() - b_dv), 32'd0);
    check("hold no_second busy", 32'(n_busy - b_busy),      32'd0);
    check("hold count_tx",       32'(count_tx),             32'd2);
    start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
